plane_controller: RTL and testbench
===================================

Name: plane_controller

Overview:
- PWM plane driver for the LED cube: OUT_NUM independent PWM channels, each with a C_WIDTH-bit duty value.
- Loaded over an HD44780-style byte bus: rs=1 selects a command, rs=0 selects data (a duty write).
- Data writes go to an address pointer that auto-increments or auto-decrements.
- Sits between the cube's host/memory interface and the plane output drivers.

Parameters:
- OUT_NUM, 8, number of PWM channels / pwmOut bits (2..64).
- D_WIDTH, 8, dataIn bus width (must be >= 8 and >= C_WIDTH).
- C_WIDTH, 5, PWM counter and duty width; PWM period = 2^C_WIDTH clk cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- dataIn  in  D_WIDTH  command byte (rs=1) or duty byte (rs=0).
- dataEn  in  1  write strobe; a write happens on its rising edge only.
- rs  in  1  register select: 1 = command, 0 = data.
- pwmOut  out  OUT_NUM  registered PWM outputs, bit i = channel i.

Behaviour:
- Strobe detection:
  - dataEn is registered into dataEn_q.
  - A write occurs in the cycle where dataEn=1 and dataEn_q=0.
  - dataEn may stay high any number of cycles; this still gives exactly one write.
  - rs and dataIn are sampled in the write cycle.
- Reset (clk edge with reset=1) sets:
  - all shadow and active duties = 0, pointer = 0, dir = increment;
  - enable = 0, counter = 0, dataEn_q = 0, pwmOut = 0.
  - Reset overrides any write in the same cycle.
- Command decode (rs=1): the highest set bit of dataIn[7:0] selects the command; lower bits are arguments.
  - 0x00: no-op.
  - 0x01 CLEAR: all shadow duties = 0, pointer = 0, dir = increment.
  - 0x02/0x03 HOME: pointer = 0.
  - 0x04-0x07 ENTRY: dir = bit1 (1 = increment, 0 = decrement); bit0 is ignored.
  - 0x08-0x0F DISPLAY: enable = bit2; bits 1:0 are ignored.
  - 0x10-0x7F: reserved, no-op.
  - 0x80-0xFF SETADDR: pointer = dataIn[6:0] if that value < OUT_NUM, else no change.
- Data write (rs=0):
  - shadow[pointer] = dataIn[C_WIDTH-1:0]; upper bits are ignored (0xF4 writes 20).
  - The pointer then steps per dir, modulo OUT_NUM: OUT_NUM-1 -> 0 when incrementing, 0 -> OUT_NUM-1 when decrementing.
- Registers update on the clock edge of the write cycle.
- PWM counter:
  - Free-running C_WIDTH-bit counter, +1 per clk, wraps from 2^C_WIDTH-1 to 0.
  - In the cycle where counter = 2^C_WIDTH-1, every active duty loads from its shadow. New duties therefore take effect at the next period start, giving glitch-free periods.
- Output:
  - pwmOut[i] <= enable & (counter < active[i]), registered with one cycle of latency.
  - Duty 0 keeps the output low.
  - Duty 2^C_WIDTH-1 gives 31 high cycles out of 32.
  - enable=0 forces all outputs low while duties are retained and the counter keeps running.
- If a write and the period-end transfer fall in the same cycle, the transfer uses the pre-write shadow. The written value appears one period later.

Optional Feature:
- PWM_ACTIVE_LOW_EN
- Defined: every pwmOut bit is inverted after the registered compare. Outputs idle high, including during reset and while enable=0.
- Undefined: outputs are active-high as specified above.

Test Plan:
- Reset: reset=1 for 5 clks, then 0 -> pwmOut=0 and no writes take effect. Data 0x10 written before DISPLAY-on -> pwmOut stays 0.
- Init sequence: 0x01, 0x02, 0x06, 0x0C with rs=1, then data 0x00, 0x01, 0x02, 0x03 with rs=0, one strobe each (dataEn high 16 clks) -> pointer = 4. Per 32-cycle period: ch0 high 0 cycles, ch1 1 cycle, ch2 2 cycles, ch3 3 cycles.
- Upper-bit masking: data 0xF4, 0xF5, 0xF6, 0xF7 after the above -> ch4..ch7 high 20, 21, 22, 23 of 32 cycles. pointer wraps to 0; a next data 0x1F gives ch0 high 31 of 32 cycles.
- Strobe edge: dataEn held high 100 clks with rs=0, data 0x05 -> exactly one channel written and pointer advances by 1.
- Decrement and SETADDR: 0x80|7, 0x04, then data 0x08, 0x09 -> ch7=8, ch6=9, pointer=5. SETADDR 0x88 (8 >= OUT_NUM) -> pointer unchanged.
- Disable and shadow timing: 0x08 -> pwmOut=0 within 2 clks. 0x0C -> original duties return. A duty change written mid-period alters the output only from the next counter wrap.

Source files
------------

// File: rtl/plane_controller.sv
// PWM plane driver: OUT_NUM duty-controlled channels loaded over an HD44780-style byte bus.
// Define PWM_ACTIVE_LOW_EN to invert every pwmOut bit (outputs then idle high).
module plane_controller #(
    parameter int OUT_NUM = 8,
    parameter int D_WIDTH = 8,
    parameter int C_WIDTH = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [D_WIDTH-1:0] dataIn,
    input  logic               dataEn,
    input  logic               rs,
    output logic [OUT_NUM-1:0] pwmOut
);

    localparam int P_WIDTH = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
    localparam logic [C_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [7:0] OUT_NUM_B = 8'(OUT_NUM);
    localparam logic [P_WIDTH-1:0] PTR_LAST = P_WIDTH'(OUT_NUM - 1);

    logic               dataEnQ;
    logic               writeEn;
    logic               cmdWrite;
    logic               dataWrite;
    logic [7:0]         cmdByte;
    logic [P_WIDTH-1:0] pointerReg, pointerNext;
    logic               dirReg, dirNext;
    logic               enableReg, enableNext;
    logic               clearAll;
    logic [C_WIDTH-1:0] counterReg;
    logic               periodEnd;
    logic [C_WIDTH-1:0] shadowReg [OUT_NUM];
    logic [C_WIDTH-1:0] activeReg [OUT_NUM];
    logic [OUT_NUM-1:0] pwmReg, pwmNext;

    // A write is the first cycle of a dataEn high pulse, however long it stays high.
    assign writeEn   = dataEn & ~dataEnQ;
    assign cmdWrite  = writeEn & rs;
    assign dataWrite = writeEn & ~rs;
    assign cmdByte   = dataIn[7:0];
    assign periodEnd = (counterReg == CNT_MAX);

    always_comb begin
        pointerNext = pointerReg;
        dirNext     = dirReg;
        enableNext  = enableReg;
        clearAll    = 1'b0;
        if (cmdWrite) begin
            // Highest set bit selects the command; lower bits are its arguments.
            if (cmdByte[7]) begin
                if ({1'b0, cmdByte[6:0]} < OUT_NUM_B)
                    pointerNext = cmdByte[P_WIDTH-1:0];
            end else if (|cmdByte[6:4]) begin
                pointerNext = pointerReg;
            end else if (cmdByte[3]) begin
                enableNext = cmdByte[2];
            end else if (cmdByte[2]) begin
                dirNext = cmdByte[1];
            end else if (cmdByte[1]) begin
                pointerNext = '0;
            end else if (cmdByte[0]) begin
                clearAll    = 1'b1;
                pointerNext = '0;
                dirNext     = 1'b1;
            end
        end else if (dataWrite) begin
            if (dirReg)
                pointerNext = (pointerReg == PTR_LAST) ? '0 : pointerReg + P_WIDTH'(1);
            else
                pointerNext = (pointerReg == '0) ? PTR_LAST : pointerReg - P_WIDTH'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < OUT_NUM; gi++) begin : g_cmp
            assign pwmNext[gi] = enableReg & (counterReg < activeReg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            dataEnQ    <= 1'b0;
            pointerReg <= '0;
            dirReg     <= 1'b1;
            enableReg  <= 1'b0;
            counterReg <= '0;
            pwmReg     <= '0;
            for (int i = 0; i < OUT_NUM; i++) begin
                shadowReg[i] <= '0;
                activeReg[i] <= '0;
            end
        end else begin
            dataEnQ    <= dataEn;
            pointerReg <= pointerNext;
            dirReg     <= dirNext;
            enableReg  <= enableNext;
            counterReg <= counterReg + C_WIDTH'(1);
            pwmReg     <= pwmNext;
            for (int i = 0; i < OUT_NUM; i++) begin
                if (clearAll)
                    shadowReg[i] <= '0;
                else if (dataWrite && (pointerReg == P_WIDTH'(i)))
                    shadowReg[i] <= dataIn[C_WIDTH-1:0];
                // Reads the pre-write shadow, so a coincident write lands one period later.
                if (periodEnd)
                    activeReg[i] <= shadowReg[i];
            end
        end
    end

`ifdef PWM_ACTIVE_LOW_EN
    assign pwmOut = ~pwmReg;
`else
    assign pwmOut = pwmReg;
`endif

endmodule

// File: tb/tb_plane_controller.sv
// Directed bench for plane_controller: write/check vector table plus hand-timed shadow/disable/reset sequences.
module tb_plane_controller;

    localparam int OUT_NUM = 8;
`ifdef PWM_ACTIVE_LOW_EN
    localparam logic ACT_LOW = 1'b1;
`else
    localparam logic ACT_LOW = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [7:0]         dataIn = '0;
    logic               dataEn = 1'b0;
    logic               rs = 1'b0;
    logic [OUT_NUM-1:0] pwmOut;
    logic [OUT_NUM-1:0] pwmAct;

    int checks = 0;
    int failures = 0;
    int hiCnt [OUT_NUM];

    plane_controller #(.OUT_NUM(OUT_NUM), .D_WIDTH(8), .C_WIDTH(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .dataIn (dataIn),
        .dataEn (dataEn),
        .rs     (rs),
        .pwmOut (pwmOut)
    );

    always #5 clk = ~clk;
    assign pwmAct = pwmOut ^ {OUT_NUM{ACT_LOW}};

    typedef struct packed {
        logic            isCheck;
        logic            rs;
        logic [7:0]      data;
        logic [7:0]      hold;
        logic [7:0][7:0] expDuty;
    } vec_t;

    vec_t tbl [64];
    int   nVec = 0;

    function automatic vec_t mkWr(logic r, logic [7:0] d, logic [7:0] h);
        vec_t v;
        v = '0;
        v.rs = r;
        v.data = d;
        v.hold = h;
        return v;
    endfunction

    function automatic vec_t mkChk(int e0, int e1, int e2, int e3, int e4, int e5, int e6, int e7);
        vec_t v;
        v = '0;
        v.isCheck = 1'b1;
        v.expDuty[0] = 8'(e0); v.expDuty[1] = 8'(e1); v.expDuty[2] = 8'(e2); v.expDuty[3] = 8'(e3);
        v.expDuty[4] = 8'(e4); v.expDuty[5] = 8'(e5); v.expDuty[6] = 8'(e6); v.expDuty[7] = 8'(e7);
        return v;
    endfunction

    task automatic add(input vec_t v);
        tbl[nVec] = v;
        nVec++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic writeOp(input logic r, input logic [7:0] d, input int hold);
        @(negedge clk);
        rs = r;
        dataIn = d;
        dataEn = 1'b1;
        repeat (hold) @(negedge clk);
        dataEn = 1'b0;
        @(negedge clk);
        $display("wr rs=%0d data=0x%02h hold=%0d", r, d, hold);
    endtask

    task automatic measure();
        for (int c = 0; c < OUT_NUM; c++) hiCnt[c] = 0;
        repeat (32) begin
            @(negedge clk);
            for (int c = 0; c < OUT_NUM; c++) if (pwmAct[c]) hiCnt[c]++;
        end
    endtask

    task automatic settleAndCheck(input string tag, input logic [7:0][7:0] exp);
        repeat (70) @(negedge clk);
        measure();
        for (int c = 0; c < OUT_NUM; c++)
            check($sformatf("%s_ch%0d", tag, c), hiCnt[c], int'(exp[c]));
        $display("chk %s duties %0d %0d %0d %0d %0d %0d %0d %0d", tag,
                 hiCnt[0], hiCnt[1], hiCnt[2], hiCnt[3], hiCnt[4], hiCnt[5], hiCnt[6], hiCnt[7]);
    endtask

    task automatic runVec(input int i);
        if (tbl[i].isCheck) settleAndCheck($sformatf("vec%0d", i), tbl[i].expDuty);
        else writeOp(tbl[i].rs, tbl[i].data, int'(tbl[i].hold));
    endtask

    // Ch0 rises only on the sample that reflects counter value 0.
    task automatic syncRise(output bit ok);
        int n;
        n = 0;
        while (n < 100 && pwmAct[0] !== 1'b0) begin @(negedge clk); n++; end
        while (n < 100 && pwmAct[0] !== 1'b1) begin @(negedge clk); n++; end
        ok = (pwmAct[0] === 1'b1);
        check("sync_rise", int'(ok), 1);
    endtask

    logic [7:0][7:0] expA;
    int splitA;
    int cnt3;
    bit ok;
    logic [OUT_NUM-1:0] anyHigh;

    initial begin
        // Part A: reset-disabled write, init sequence, masking, strobe edge, decrement, SETADDR.
        add(mkWr(0, 8'h10, 1));
        add(mkChk(0, 0, 0, 0, 0, 0, 0, 0));
        add(mkWr(1, 8'h01, 16)); add(mkWr(1, 8'h02, 16)); add(mkWr(1, 8'h06, 16)); add(mkWr(1, 8'h0C, 16));
        add(mkWr(0, 8'h00, 16)); add(mkWr(0, 8'h01, 16)); add(mkWr(0, 8'h02, 16)); add(mkWr(0, 8'h03, 16));
        add(mkChk(0, 1, 2, 3, 0, 0, 0, 0));
        add(mkWr(0, 8'hF4, 2)); add(mkWr(0, 8'hF5, 2)); add(mkWr(0, 8'hF6, 2)); add(mkWr(0, 8'hF7, 2));
        add(mkWr(0, 8'h1F, 2));
        add(mkChk(31, 1, 2, 3, 20, 21, 22, 23));
        add(mkWr(0, 8'h05, 100)); add(mkWr(0, 8'h0A, 1));
        add(mkChk(31, 5, 10, 3, 20, 21, 22, 23));
        add(mkWr(1, 8'h87, 1)); add(mkWr(1, 8'h04, 1)); add(mkWr(0, 8'h08, 1)); add(mkWr(0, 8'h09, 1));
        add(mkWr(1, 8'h88, 1)); add(mkWr(0, 8'h0B, 1));
        add(mkWr(1, 8'h80, 1)); add(mkWr(0, 8'h0C, 1)); add(mkWr(0, 8'h0D, 1));
        add(mkChk(12, 5, 10, 3, 20, 11, 9, 13));
        add(mkWr(1, 8'h07, 1)); add(mkWr(1, 8'h03, 1)); add(mkWr(0, 8'h1E, 1));
        add(mkWr(1, 8'h0F, 1)); add(mkWr(1, 8'h20, 1)); add(mkWr(0, 8'h11, 1));
        add(mkChk(30, 17, 10, 3, 20, 11, 9, 13));
        splitA = nVec;
        // Part B: CLEAR also restores increment direction and pointer 0.
        add(mkWr(1, 8'h04, 1)); add(mkWr(1, 8'h01, 1)); add(mkWr(0, 8'h15, 1)); add(mkWr(0, 8'h16, 1));
        add(mkChk(21, 22, 0, 0, 0, 0, 0, 0));

        // Reset for 5 clocks with a command strobe buried inside it.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        rs = 1'b1; dataIn = 8'h0C; dataEn = 1'b1;
        @(negedge clk);
        dataEn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out", int'(pwmAct), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_out", int'(pwmAct), 0);

        for (int i = 0; i < splitA; i++) runVec(i);

        // Disable: outputs low within 2 clocks and for a whole period.
        writeOp(1, 8'h08, 1);
        check("disable_2clk", int'(pwmAct), 0);
        anyHigh = '0;
        repeat (40) begin @(negedge clk); anyHigh |= pwmAct; end
        check("disable_hold", int'(anyHigh), 0);
        writeOp(1, 8'h0C, 1);
        expA[0] = 30; expA[1] = 17; expA[2] = 10; expA[3] = 3;
        expA[4] = 20; expA[5] = 11; expA[6] = 9;  expA[7] = 13;
        settleAndCheck("reenable", expA);

        // Mid-period write to ch3 only shows from the next wrap.
        writeOp(1, 8'h83, 1);
        syncRise(ok);
        cnt3 = 0;
        for (int i = 0; i < 32; i++) begin
            if (pwmAct[3]) cnt3++;
            if (i == 10) begin rs = 1'b0; dataIn = 8'h14; dataEn = 1'b1; end
            if (i == 11) dataEn = 1'b0;
            @(negedge clk);
        end
        check("midwrite_same_period", cnt3, 3);
        cnt3 = 0;
        for (int i = 0; i < 32; i++) begin if (pwmAct[3]) cnt3++; @(negedge clk); end
        check("midwrite_next_period", cnt3, 20);
        $display("seq midwrite ch3 -> 20");

        // Write coinciding with the period-end transfer appears one period later.
        writeOp(1, 8'h83, 1);
        syncRise(ok);
        cnt3 = 0;
        for (int i = 0; i < 32; i++) begin
            if (pwmAct[3]) cnt3++;
            if (i == 30) begin rs = 1'b0; dataIn = 8'h07; dataEn = 1'b1; end
            if (i == 31) dataEn = 1'b0;
            @(negedge clk);
        end
        check("edgewrite_cur", cnt3, 20);
        cnt3 = 0;
        for (int i = 0; i < 32; i++) begin if (pwmAct[3]) cnt3++; @(negedge clk); end
        check("edgewrite_pre_shadow", cnt3, 20);
        cnt3 = 0;
        for (int i = 0; i < 32; i++) begin if (pwmAct[3]) cnt3++; @(negedge clk); end
        check("edgewrite_new", cnt3, 7);
        $display("seq edgewrite ch3 -> 7");

        for (int i = splitA; i < nVec; i++) runVec(i);

        // Mid-run reset clears duties and enable.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_reset_out", int'(pwmAct), 0);
        reset = 1'b0;
        writeOp(1, 8'h0C, 1);
        for (int c = 0; c < OUT_NUM; c++) expA[c] = 0;
        settleAndCheck("after_reset", expA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
